mem_access: RTL
===============

# mem_access

Load/store responder for the multicycle core's memory stage. It accepts a one-cycle `enabled` pulse with the decoded access (funct3, byte address, store data) and performs one aligned RV32I load or store on a synchronous single-port data RAM. It then raises `completed` with the extended load result, using the same enabled/completed handshake as the decode and execute stages. It sits between execute and write-back.

## Interface
Parameters:
- `ADDR_W`, 12: word-address width of the data RAM (16 KiB).
- `RD_LATENCY`, 1: cycles from registered `mem_addr` to valid `mem_rdata`; range 1–3.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `enabled`  in  1  one-cycle start pulse from the core.
- `is_load`  in  1  the access is a load.
- `is_store`  in  1  the access is a store; `is_load` and `is_store` are never both 1.
- `funct3`  in  3  access width and extension.
- `addr`  in  32  byte address (rs1 + imm, from execute).
- `wdata`  in  32  store data (rs2).
- `completed`  out  1  access finished; held high until the next accepted `enabled` or reset.
- `rdata`  out  32  extended load result; 0 for stores, no-ops and faults.
- `fault`  out  1  misaligned address or illegal funct3; valid while `completed` is high.
- `mem_addr`  out  ADDR_W  word address, `addr[ADDR_W+1:2]`.
- `mem_we`  out  4  byte write enables; bit i writes byte lane i.
- `mem_wdata`  out  32  lane-positioned write data.
- `mem_rdata`  in  32  RAM read data.

## Operation
- Encodings: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores accept only 000, 001 and 010. Any other code gives `fault`=1.
- Misaligned access gives `fault`=1: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
- A faulting access never touches the RAM: `mem_we` stays 0 and no read is issued.
- Byte lanes are little-endian. Lane = `addr[1:0]`.
- SB: `mem_we` = 1<<lane, and the byte is replicated into all four lanes of `mem_wdata`.
- SH: `mem_we` = 0011 if `addr[1]`=0, else 1100. The halfword is replicated into both halves.
- SW: `mem_we` = 1111.
- Loads select the lane from the captured `mem_rdata`. B and H sign-extend; BU and HU zero-extend; W passes through.
- If `is_load` and `is_store` are both 0, the access is a no-op: `completed` is raised, `rdata`=0, `fault`=0.
- State machine:
  - IDLE: on `enabled`, latch the inputs; go to ACCESS, or to DONE if the access is a fault or no-op.
  - ACCESS: registered memory outputs are valid for exactly one cycle. A store goes to DONE. A load loads the wait counter with RD_LATENCY-1 and goes to WAIT.
  - WAIT: decrement the counter. At 0, capture and extend `mem_rdata` into `rdata`, then go to DONE.
  - DONE: `completed`=1. A new `enabled` is accepted here exactly as in IDLE.
- `enabled` in ACCESS or WAIT is ignored.
- Reset values: all outputs 0, state IDLE, counter 0.

## Timing
Cycle T is the cycle in which `enabled` is high.
- Store: `mem_we`/`mem_addr`/`mem_wdata` are valid in T+1 only, the RAM writes at the end of T+1, and `completed` rises at T+2.
- Load: `mem_addr` is valid in T+1 and `rdata` is captured at the end of T+1+RD_LATENCY. `completed` and `rdata` rise together at T+2+RD_LATENCY, which is T+3 at the default latency.
- Fault or no-op: `completed` rises at T+1. `mem_we` is never asserted.
- `mem_we` returns to 0 in T+2 with no stuck enables.
- Re-enable in DONE at cycle U: `completed` drops at U+1 and follows the timing above.
- `rstn` low at any edge forces IDLE and clears all outputs from the next cycle. A store whose ACCESS cycle coincides with reset is dropped (`mem_we` forced 0). A load in progress is abandoned and `mem_rdata` is ignored.

## Structure
- Add the funct3 width constants (LS_B, LS_H, LS_W, LS_BU, LS_HU) and the state enum (IDLE, ACCESS, WAIT, DONE) to the shared `def.sv` package, beside `instructions`.
- One combinational sub-module, `mem_load_align`, covers lane select and sign/zero extension. Inputs: `mem_rdata`, lane, funct3. Output: 32-bit result.
- The FSM, input latches, wait counter and store lane formatting stay in `mem_access`.

## Test plan
- SW `addr`=0x10, `wdata`=0xDEADBEEF → T+1: `mem_addr`=4, `mem_we`=1111, `mem_wdata`=0xDEADBEEF; `completed` at T+2; `rdata`=0.
- SB `addr`=0x13, `wdata`=0x000000A5 → `mem_we`=1000, `mem_wdata`=0xA5A5A5A5. A following LW of 0x10 returns 0xA5ADBEEF at T+3.
- With RAM word 4 = 0x80FF7F01:
  - LB 0x12 → 0xFFFFFFFF; LBU 0x12 → 0x000000FF.
  - LH 0x12 → 0xFFFF80FF; LHU 0x10 → 0x00007F01.
  - Repeat with RD_LATENCY=3: `completed` at T+5.
- Fault cases, each: `fault`=1, `completed` at T+1, `mem_we` never set, RAM unchanged:
  - LW 0x11.
  - SH 0x13.
  - Store with funct3=100.
- `enabled` pulsed again during WAIT is ignored. A second `enabled` in DONE drops `completed` at U+1 and completes the new access normally.
- SW issued, then `rstn` low during the ACCESS cycle → no write (RAM word unchanged), all outputs 0 at the next cycle, state IDLE.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory stage: load/store width codes, FSM states
// and the fault decode used when an access is accepted.
package mem_access_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Illegal width code or misaligned address; no-ops never fault.
    function automatic logic access_fault(input logic       is_load,
                                          input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] lane);
        logic bad_code;
        logic misal;
        bad_code = 1'b0;
        misal    = 1'b0;
        case (funct3)
            LS_B:    ;
            LS_H:    misal = lane[0];
            LS_W:    misal = |lane;
            LS_BU:   bad_code = is_store;
            LS_HU:   begin bad_code = is_store; misal = lane[0]; end
            default: bad_code = 1'b1;
        endcase
        return (is_load | is_store) & (bad_code | misal);
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load lane select and sign/zero extension of the raw RAM word.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed byte/halfword, then extend according to funct3.
    always_comb begin
        case (lane)
            2'd0:    byte_v = mem_rdata[7:0];
            2'd1:    byte_v = mem_rdata[15:8];
            2'd2:    byte_v = mem_rdata[23:16];
            default: byte_v = mem_rdata[31:24];
        endcase
        half_v = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3)
            LS_B:    result = {{24{byte_v[7]}}, byte_v};
            LS_BU:   result = {24'd0, byte_v};
            LS_H:    result = {{16{half_v[15]}}, half_v};
            LS_HU:   result = {16'd0, half_v};
            LS_W:    result = mem_rdata;
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-stage load/store responder: one aligned RV32I access per enabled
// pulse on a synchronous single-port RAM, reported through completed/rdata.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enabled,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              completed,
    output logic [31:0]       rdata,
    output logic              fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q, state_d;
    logic              is_load_q, is_load_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              completed_q, completed_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic [31:0] load_result;
    logic        new_fault;
    logic [3:0]  st_we;
    logic [31:0] st_data;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    mem_load_align u_align (
        .mem_rdata (mem_rdata),
        .lane      (lane_q),
        .funct3    (f3_q),
        .result    (load_result)
    );

    // Store lane enables and replicated write data for the incoming access.
    always_comb begin
        new_fault = access_fault(is_load, is_store, funct3, addr[1:0]);
        case (funct3)
            LS_B:    begin st_we = 4'b0001 << addr[1:0]; st_data = {4{wdata[7:0]}}; end
            LS_H:    begin st_we = addr[1] ? 4'b1100 : 4'b0011; st_data = {2{wdata[15:0]}}; end
            default: begin st_we = 4'b1111; st_data = wdata; end
        endcase
    end

    // Next-state and registered-output logic for the access FSM.
    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        completed_d = completed_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 4'b0000;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE, DONE: begin
                if (enabled) begin
                    is_load_d   = is_load;
                    f3_d        = funct3;
                    lane_d      = addr[1:0];
                    rdata_d     = 32'd0;
                    fault_d     = new_fault;
                    if (new_fault || !(is_load || is_store)) begin
                        state_d     = DONE;
                        completed_d = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        completed_d = 1'b0;
                        mem_addr_d  = addr[ADDR_W+1:2];
                        if (is_store) begin
                            mem_we_d    = st_we;
                            mem_wdata_d = st_data;
                        end
                    end
                end
            end
            ACCESS: begin
                if (is_load_q) begin
                    cnt_d   = 2'(RD_LATENCY - 1);
                    state_d = WAIT;
                end else begin
                    state_d     = DONE;
                    completed_d = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d     = load_result;
                    completed_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            is_load_q   <= 1'b0;
            f3_q        <= 3'd0;
            lane_q      <= 2'd0;
            cnt_q       <= 2'd0;
            completed_q <= 1'b0;
            rdata_q     <= 32'd0;
            fault_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 4'b0000;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            completed_q <= completed_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign completed = completed_q;
    assign rdata     = rdata_q;
    assign fault     = fault_q;
    assign mem_addr  = mem_addr_q;
    // A store whose write cycle meets reset must not reach the RAM.
    assign mem_we    = mem_we_q & {4{rstn}};
    assign mem_wdata = mem_wdata_q;

endmodule
